data_mem_responder: RTL
=======================

# data_mem_responder

Word-organised data memory that answers the core's data-side access port (wr, rd, addr, wr_data to the memory; rd_data back to the core). It sits directly beside the core top level and closes the load/store path. It owns a post-reset clear sequencer, saturating access counters for fault-injection campaigns, and an optional per-word parity check that flags corrupted reads.

## Interface
- DATA_W, 32, data word width; matches the core's wr_data/rd_data
- ADDR_W, 9, byte-address width of addr
- DEPTH, 128, number of words (2^(ADDR_W-2))
- CNT_W, 16, width of each access counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (name fixed to the codebase's name; asserted at 0)
- wr  in  1  write strobe from the core
- rd  in  1  read strobe from the core
- addr  in  ADDR_W  byte address; word index = addr[ADDR_W-1:2]
- wr_data  in  DATA_W  store data
- rd_data  out  DATA_W  load data, combinational
- clr_req  in  1  single-cycle request to re-zero the array
- par_inject  in  1  when high together with an accepted write, store inverted parity (fault-injection hook)
- busy  out  1  clear sequence in progress
- misalign  out  1  sticky: an access arrived with addr[1:0] != 0
- err  out  1  sticky parity error
- rd_cnt  out  CNT_W  accepted reads, saturating
- wr_cnt  out  CNT_W  accepted writes, saturating

## Operation
- FSM states: CLEAR and READY. Reset forces CLEAR with the sweep pointer at 0.
- CLEAR: one word is zeroed per cycle (pointer 0..DEPTH-1), with correct parity stored for zero. The state moves to READY on the edge that writes word DEPTH-1. busy = 1 throughout.
- READY: wr=1 writes wr_data to word addr[ADDR_W-1:2] at the edge. rd=1 gives rd_data = array[word] combinationally.
- READY with clr_req=1: moves to CLEAR, resets the pointer, and clears misalign, err, rd_cnt and wr_cnt. Any wr in that same cycle is dropped.
- In CLEAR, wr and rd are not accepted: no array update, rd_data = 0, counters frozen, clr_req ignored.
- rd_data = 0 whenever rd = 0 or busy = 1.
- wr and rd both high in the same cycle: both are accepted. rd_data returns the old content; the new data is visible from the next cycle. Both counters increment.
- An access is accepted when it is wr or rd with busy = 0. Each accepted access with addr[1:0] != 0 sets misalign; the low bits are otherwise ignored.
- Counters increment by 1 per accepted access and hold at 2^CNT_W-1.
- Reset asserted mid-CLEAR or mid-access: everything aborts immediately and the sweep restarts from 0 after release.

## Timing
- Reset values: busy=1, misalign=0, err=0, rd_cnt=0, wr_cnt=0, rd_data=0.
- Clear sequence is exactly DEPTH cycles after reset release or clr_req. busy falls after DEPTH rising edges.
- Write latency: 1 edge. Read latency: 0 cycles (combinational).
- misalign and err update on the edge of the offending access and are visible the next cycle.
- Counters are visible the cycle after the access.

## Configuration
- DMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit of its data, inverted when par_inject=1 on the write.
  - An accepted read whose stored parity mismatches the data sets err on that edge.
  - rd_data still returns the stored data unchanged.
- DMEM_PARITY_EN undefined:
  - No parity storage.
  - err is tied to 0 and par_inject is ignored.

## Test plan
- Release reset, count cycles → busy high for exactly 128 cycles. Then read every word → all 0, rd_cnt=128.
- In READY, write 0xDEADBEEF to addr 0x010, read addr 0x010 next cycle → 0xDEADBEEF. Read addr 0x014 → 0x00000000.
- wr and rd to addr 0x020 in the same cycle (old value 0x0, new 0x12345678) → rd_data 0x0 that cycle, 0x12345678 the next. wr_cnt and rd_cnt each +1.
- Write to addr 0x003 → misalign=1 next cycle and word 0 updated. clr_req pulse → misalign=0, busy=1 for 128 cycles, counters 0.
- (DMEM_PARITY_EN) Write 0xA5A5A5A5 with par_inject=1 to addr 0x040, then read it → rd_data 0xA5A5A5A5 and err=1 the next cycle. Without the macro, the same sequence → err stays 0.
- Assert reset at sweep pointer 60 → busy stays 1 and outputs take reset values. After release, busy lasts a full 128 cycles. Drive rd_cnt to 0xFFFF → further reads leave it at 0xFFFF.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Core data-side access port: load/store strobes, byte address, store data and load data.
interface data_mem_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
);
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (output wr, rd, addr, wr_data, input rd_data);
    modport slave  (input wr, rd, addr, wr_data, output rd_data);
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with post-reset clear sweep, saturating access counters and
// optional per-word parity checking (enabled by defining DMEM_PARITY_EN).
module data_mem_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    data_mem_responder_if.slave       bus,
    input  logic                      clr_req,
    input  logic                      par_inject,
    output logic                      busy,
    output logic                      misalign,
    output logic                      err,
    output logic [CNT_W-1:0]          rd_cnt,
    output logic [CNT_W-1:0]          wr_cnt
);
    localparam int unsigned IDX_W = ADDR_W - 2;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              busy_w;
    logic              rd_acc;
    logic              wr_acc;
    logic              any_acc;
    logic              clr_go;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idx     = bus.addr[ADDR_W-1:2];
    assign rd_word = mem_q[idx];
    assign busy_w  = (state_q == StClear);
    assign clr_go  = !busy_w && clr_req;
    assign rd_acc  = bus.rd && !busy_w;
    // A store arriving together with a clear request is dropped.
    assign wr_acc  = bus.wr && !busy_w && !clr_req;
    assign any_acc = (bus.rd || bus.wr) && !busy_w;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end
            end
            StReady: begin
                if (clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        misalign_d = misalign_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        if (clr_go) begin
            misalign_d = 1'b0;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
        end else begin
            if (any_acc && (bus.addr[1:0] != 2'b00)) begin
                misalign_d = 1'b1;
            end
            if (rd_acc && (rd_cnt_q != {CNT_W{1'b1}})) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (wr_acc && (wr_cnt_q != {CNT_W{1'b1}})) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    // The sweep owns the write port while clearing; otherwise accepted stores use it.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = bus.wr_data;
        if (busy_w) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StClear;
            ptr_q      <= '0;
            misalign_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            misalign_q <= misalign_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_mem_q [DEPTH];
    logic mem_wpar;
    logic rd_par_bad;
    logic err_q, err_d;

    // Even parity; par_inject flips it only for an accepted store.
    assign mem_wpar   = (^mem_wdata) ^ (wr_acc & par_inject);
    assign rd_par_bad = rd_acc && ((^rd_word) != par_mem_q[idx]);

    always_comb begin
        err_d = err_q;
        if (clr_go) begin
            err_d = 1'b0;
        end else if (rd_par_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem_q[mem_waddr] <= mem_wpar;
        end
    end

    assign err = err_q;
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign err = 1'b0;
`endif

    assign bus.rd_data = rd_acc ? rd_word : '0;
    assign busy        = busy_w;
    assign misalign    = misalign_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
endmodule
